// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter for the unified memory of the multicycle core.
// Port 0 is the CPU datapath, port 1 the loader/debug port; one access in flight at a time.
module mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          Reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_done,
  output logic          cpu_stall,
  input  logic          ldr_req,
  input  logic          ldr_we,
  input  logic [AW-1:0] ldr_addr,
  input  logic [DW-1:0] ldr_wdata,
  output logic [DW-1:0] ldr_rdata,
  output logic          ldr_done,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          err,
  output logic [1:0]    state_dbg
);

  // Handshake: a requester holds req (and its we/addr/wdata) until its done pulse;
  // the arbiter samples req only in IDLE, so req must drop on the edge after done.

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;

  localparam int            CW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_CNT = CW'(TIMEOUT);

  state_t        state_q, state_d;
  logic          owner_q, owner_d;   // 0 = CPU, 1 = loader
  logic          last_q, last_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0] ldr_rdata_q, ldr_rdata_d;
  logic          err_q, err_d;
  logic          timeout_hit;
  logic          grant_ldr;

  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TO_CNT);
  // On a tie the loader wins only if the CPU was served last.
  assign grant_ldr   = ldr_req & (~cpu_req | ~last_q);

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      last_q      <= 1'b1;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      cpu_rdata_q <= '0;
      ldr_rdata_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      cpu_rdata_q <= cpu_rdata_d;
      ldr_rdata_q <= ldr_rdata_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cpu_req | ldr_req) state_d = BUSY;
      BUSY:    if (mem_ready | timeout_hit) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    owner_d     = owner_q;
    last_d      = last_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    cpu_rdata_d = cpu_rdata_q;
    ldr_rdata_d = ldr_rdata_q;
    err_d       = err_q;
    if (state_q == IDLE && (cpu_req | ldr_req)) begin
      owner_d = grant_ldr;
      we_d    = grant_ldr ? ldr_we    : cpu_we;
      addr_d  = grant_ldr ? ldr_addr  : cpu_addr;
      wdata_d = grant_ldr ? ldr_wdata : cpu_wdata;
      cnt_d   = '0;
    end else if (state_q == BUSY) begin
      // mem_ready wins over the watchdog when both land in the same cycle.
      if (mem_ready | timeout_hit) begin
        last_d = owner_q;
        if (!mem_ready) err_d = 1'b1;
        if (!we_q) begin
          if (owner_q) ldr_rdata_d = mem_ready ? mem_rdata : '0;
          else         cpu_rdata_d = mem_ready ? mem_rdata : '0;
        end
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_comb begin
    mem_en    = (state_q == BUSY);
    mem_we    = (state_q == BUSY) & we_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    cpu_done  = (state_q == RESP) & ~owner_q;
    ldr_done  = (state_q == RESP) & owner_q;
    cpu_stall = cpu_req & ~cpu_done;
    cpu_rdata = cpu_rdata_q;
    ldr_rdata = ldr_rdata_q;
    err       = err_q;
    state_dbg = state_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: table of single accesses, plus reset-abort, tie and
// watchdog-edge sequences; a scoreboard queue checks each done pulse.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TIMEOUT = 15;

  logic          clk = 1'b0;
  logic          Reset;
  logic          cpu_req, cpu_we, ldr_req, ldr_we;
  logic [AW-1:0] cpu_addr, ldr_addr, mem_addr;
  logic [DW-1:0] cpu_wdata, ldr_wdata, cpu_rdata, ldr_rdata, mem_wdata, mem_rdata;
  logic          cpu_done, cpu_stall, ldr_done, mem_en, mem_we, mem_ready, err;
  logic [1:0]    state_dbg;

  mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .Reset(Reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .cpu_stall(cpu_stall),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_rdata(ldr_rdata), .ldr_done(ldr_done),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .err(err), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard entry: {port, we, addr[15:0], busy_cycles[7:0], rdata[31:0]}
  logic [57:0] exp_q[$];

  // ---------------- memory responder ----------------
  int          wait_cfg = 0;
  logic [31:0] mrdata_cfg = '0;
  int          bcnt = 0;

  assign mem_rdata = mrdata_cfg;

  always @(negedge clk) begin
    if (mem_en) begin
      mem_ready = (bcnt == wait_cfg);
      bcnt++;
    end else begin
      mem_ready = 1'b0;
      bcnt = 0;
    end
  end

  // ---------------- monitor ----------------
  int          busy = 0;
  logic [15:0] m_addr;
  logic        m_we;
  logic [31:0] m_wdata;
  bit          stable;

  always @(negedge clk) begin
    logic [57:0] e;
    if (cpu_req && !Reset) chk("cpu_stall", cpu_stall, !cpu_done);
    if (cpu_done && ldr_done) chk("both_done", 1, 0);
    if (mem_en) begin
      if (busy == 0) begin
        m_addr = mem_addr[15:0]; m_we = mem_we; m_wdata = mem_wdata; stable = 1'b1;
      end else if (mem_addr[15:0] != m_addr || mem_we != m_we || mem_wdata != m_wdata) begin
        stable = 1'b0;
      end
      busy++;
    end else if (cpu_done || ldr_done) begin
      if (exp_q.size() == 0) begin
        chk("spurious_done", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("grant_port", ldr_done, e[57]);
        chk("bus_we", m_we, e[56]);
        chk("bus_addr", m_addr, e[55:40]);
        chk("busy_cycles", busy, e[39:32]);
        chk("bus_stable", stable, 1);
        chk("rdata", ldr_done ? ldr_rdata : cpu_rdata, e[31:0]);
      end
      busy = 0;
    end else begin
      busy = 0;
    end
  end

  // ---------------- driver ----------------
  task automatic do_access(input bit port, input bit we, input logic [15:0] addr,
                           input logic [31:0] wdata, input logic [31:0] mrdata,
                           input int waits, input logic [31:0] exp_rdata, input bit exp_err);
    int busy_exp;
    int n;
    bit seen;
    busy_exp = (waits > TIMEOUT) ? TIMEOUT + 1 : waits + 1;
    exp_q.push_back({port, we, addr, 8'(busy_exp), exp_rdata});
    @(negedge clk);
    wait_cfg = waits;
    mrdata_cfg = mrdata;
    if (port) begin
      ldr_we = we; ldr_addr = {16'h0, addr}; ldr_wdata = wdata; ldr_req = 1'b1;
    end else begin
      cpu_we = we; cpu_addr = {16'h0, addr}; cpu_wdata = wdata; cpu_req = 1'b1;
    end
    n = 0;
    seen = 1'b0;
    while (!seen && n < 60) begin
      @(negedge clk);
      n++;
      seen = port ? ldr_done : cpu_done;
    end
    chk("done_seen", seen, 1);
    chk("latency", n, busy_exp + 1);
    cpu_req = 1'b0;
    ldr_req = 1'b0;
    chk("err", err, exp_err);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    Reset = 1'b1;
    cpu_req = 1'b0;
    ldr_req = 1'b0;
    repeat (2) @(negedge clk);
    Reset = 1'b0;
  endtask

  typedef struct {
    bit          port;
    bit          we;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [31:0] mrdata;
    int          waits;
    logic [31:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  vec_t vec[9];

  initial begin
    int n;
    vec[0] = '{1'b0, 1'b0, 16'h0010, 32'h0,        32'hE3A01005, 0,   32'hE3A01005, 1'b0};
    vec[1] = '{1'b1, 1'b1, 16'h0040, 32'hDEADBEEF, 32'h11111111, 3,   32'h00000000, 1'b0};
    vec[2] = '{1'b1, 1'b0, 16'h0044, 32'h0,        32'h12345678, 1,   32'h12345678, 1'b0};
    vec[3] = '{1'b0, 1'b1, 16'h0020, 32'h55AA55AA, 32'h22222222, 2,   32'hE3A01005, 1'b0};
    vec[4] = '{1'b0, 1'b0, 16'h0014, 32'h0,        32'hA5A5A5A5, 0,   32'hA5A5A5A5, 1'b0};
    vec[5] = '{1'b1, 1'b1, 16'h0048, 32'hCAFEBABE, 32'h33333333, 0,   32'h12345678, 1'b0};
    vec[6] = '{1'b0, 1'b0, 16'h0018, 32'h0,        32'h44444444, 255, 32'h00000000, 1'b1};
    vec[7] = '{1'b0, 1'b0, 16'h001C, 32'h0,        32'h0BADF00D, 0,   32'h0BADF00D, 1'b1};
    vec[8] = '{1'b1, 1'b0, 16'h0050, 32'h0,        32'h87654321, 5,   32'h87654321, 1'b1};

    Reset = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    ldr_req = 1'b0; ldr_we = 1'b0; ldr_addr = '0; ldr_wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_state", state_dbg, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    chk("rst_ldr_rdata", ldr_rdata, 0);
    chk("rst_err", err, 0);
    Reset = 1'b0;

    for (int i = 0; i < 9; i++)
      do_access(vec[i].port, vec[i].we, vec[i].addr, vec[i].wdata, vec[i].mrdata,
                vec[i].waits, vec[i].exp_rdata, vec[i].exp_err);

    // Reset in the middle of a stalled loader read abandons it.
    @(negedge clk);
    wait_cfg = 255;
    ldr_we = 1'b0; ldr_addr = 32'h60; ldr_req = 1'b1;
    repeat (4) @(negedge clk);
    chk("abort_in_busy", mem_en, 1);
    Reset = 1'b1;
    ldr_req = 1'b0;
    @(negedge clk);
    Reset = 1'b0;
    chk("abort_state", state_dbg, 0);
    chk("abort_mem_en", mem_en, 0);
    chk("abort_ldr_done", ldr_done, 0);
    chk("abort_ldr_rdata", ldr_rdata, 0);
    chk("abort_err", err, 0);
    do_access(1'b0, 1'b0, 16'h0030, 32'h0, 32'h5A5A0000, 0, 32'h5A5A0000, 1'b0);

    // Both ports held high after reset: strict alternation starting with the CPU.
    apply_reset();
    @(negedge clk);
    wait_cfg = 0;
    mrdata_cfg = 32'hCAFE0001;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back({1'b0, 1'b0, 16'h0100, 8'd1, 32'hCAFE0001});
      exp_q.push_back({1'b1, 1'b0, 16'h0200, 8'd1, 32'hCAFE0001});
    end
    cpu_we = 1'b0; cpu_addr = 32'h100; ldr_we = 1'b0; ldr_addr = 32'h200;
    cpu_req = 1'b1; ldr_req = 1'b1;
    n = 0;
    for (int c = 0; c < 40 && n < 4; c++) begin
      @(negedge clk);
      if (cpu_done || ldr_done) n++;
    end
    cpu_req = 1'b0; ldr_req = 1'b0;
    chk("tie_done_count", n, 4);

    // mem_ready on the very cycle the watchdog would fire: normal completion.
    do_access(1'b0, 1'b0, 16'h0070, 32'h0, 32'h600DF00D, TIMEOUT, 32'h600DF00D, 1'b0);

    repeat (3) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
